// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types and default constants for the ALU arbiter.
//   state_t     : sequencing states IDLE / EXEC / RESP
//   DW_DEF      : default operand / instruction / result width
//   OPW_DEF     : default opcode width driven to the ALU
//   OP_LSB_DEF  : default LSB of the opcode field in the instruction word
package alu_arb_pkg;

  localparam int DW_DEF     = 32;
  localparam int OPW_DEF    = 6;
  localparam int OP_LSB_DEF = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arb_rr.sv
// alu_arb_rr: two-way round-robin grant.
//   valid      in  2  request valid per requester (bit N = requester N)
//   last_grant in  1  id of the requester served most recently
//   grant      out 1  id of the winning requester (meaningful when any_valid)
//   any_valid  out 1  at least one requester is valid
module alu_arb_rr (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant,
  output logic       any_valid
);

  always_comb begin
    any_valid = |valid;
    // On a tie the requester that was not served last wins; otherwise the
    // single valid requester wins (valid[1] alone -> 1, valid[0] alone -> 0).
    if (valid == 2'b11) grant = ~last_grant;
    else                grant = valid[1];
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// An accepted operation latches operands and opcode toward the ALU, captures
// the ALU result one cycle later and presents it until the owner takes it.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid / reqN_ready        request handshake per requester
//   reqN_in1, reqN_in2, reqN_instr request operands and instruction word
//   rspN_valid / rspN_ready        response handshake per requester
//   rsp_out                        shared result register
//   alu_in1, alu_in2, alu_op       registered operands / opcode to the ALU
//   alu_out                        combinational ALU result
//   state_dbg                      current sequencing state
//   grant_cnt0, grant_cnt1         accept counters (only with ALU_ARB_STATS_EN)
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. reqN_ready is combinational from reqN_valid and state and is only
// ever high in IDLE for the granted requester. rspN_valid stays high, with
// rsp_out stable, until rspN_ready is seen.
//
// Optional feature macro: ALU_ARB_STATS_EN adds 16-bit per-requester accept
// counters that wrap 0xFFFF -> 0.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DW     = DW_DEF,
  parameter int OPW    = OPW_DEF,
  parameter int OP_LSB = OP_LSB_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic           req1_valid,
  output logic           req0_ready,
  output logic           req1_ready,
  input  logic [DW-1:0]  req0_in1,
  input  logic [DW-1:0]  req0_in2,
  input  logic [DW-1:0]  req1_in1,
  input  logic [DW-1:0]  req1_in2,
  input  logic [DW-1:0]  req0_instr,
  input  logic [DW-1:0]  req1_instr,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  input  logic           rsp0_ready,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp_out,
  output logic [DW-1:0]  alu_in1,
  output logic [DW-1:0]  alu_in2,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_out,
  output state_t         state_dbg
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [15:0]    grant_cnt0,
  output logic [15:0]    grant_cnt1
`endif
);

  state_t         state;
  logic           last_grant;
  logic           grant_id;
  logic           grant;
  logic           any_valid;
  logic           accept;
  logic           rsp_take;
  logic [DW-1:0]  sel_in1;
  logic [DW-1:0]  sel_in2;
  logic [DW-1:0]  sel_instr;
  // Instruction bits outside the opcode field are decoded elsewhere.
  logic           unused_instr_bits;

  alu_arb_rr u_rr (
    .valid      ({req1_valid, req0_valid}),
    .last_grant (last_grant),
    .grant      (grant),
    .any_valid  (any_valid)
  );

  assign unused_instr_bits = ^{req0_instr, req1_instr};

  // Reset gates the accept so no requester sees ready while rst is high.
  assign accept     = (state == IDLE) && any_valid && !rst;
  assign req0_ready = accept && !grant;
  assign req1_ready = accept &&  grant;

  assign sel_in1   = grant ? req1_in1   : req0_in1;
  assign sel_in2   = grant ? req1_in2   : req0_in2;
  assign sel_instr = grant ? req1_instr : req0_instr;

  assign rsp0_valid = (state == RESP) && !grant_id;
  assign rsp1_valid = (state == RESP) &&  grant_id;
  assign rsp_take   = grant_id ? rsp1_ready : rsp0_ready;
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant_id   <= 1'b0;
      alu_in1    <= '0;
      alu_in2    <= '0;
      alu_op     <= '0;
      rsp_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_in1  <= sel_in1;
            alu_in2  <= sel_in2;
            alu_op   <= sel_instr[OP_LSB +: OPW];
            grant_id <= grant;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_out <= alu_out;
          state   <= RESP;
        end
        RESP: begin
          // Fairness history only advances once the result is delivered.
          if (rsp_take) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req0_valid && req0_ready) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req1_valid && req1_ready) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: operand, instruction and result width.
REQ-002 SHALL have parameter OPW, default 6: opcode width driven to the ALU.
REQ-003 SHALL have parameter OP_LSB, default 26: LSB of the opcode field in the instruction word (bits OP_LSB+OPW-1:OP_LSB).
REQ-004 SHALL have ports as listed; one clock; reset is synchronous and active-high:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid, req1_valid  in  1  requester N presents an operation.
- req0_ready, req1_ready  out  1  requester N's operation accepted this cycle.
- req0_in1, req0_in2, req1_in1, req1_in2  in  DW  operands.
- req0_instr, req1_instr  in  DW  instruction word.
- rsp0_valid, rsp1_valid  out  1  result available for requester N.
- rsp0_ready, rsp1_ready  in  1  requester N takes the result.
- rsp_out  out  DW  result register, shared by both requesters.
- alu_in1, alu_in2  out  DW  registered operands to the external ALU32.
- alu_op  out  OPW  registered opcode to the external ALU32.
- alu_out  in  DW  combinational ALU result.

Function
REQ-005 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-006 IDLE: if any reqN_valid, grant one requester; assert its reqN_ready in the same cycle (combinational from valid and state); latch in1, in2 and instr[OP_LSB+OPW-1:OP_LSB] into alu_in1/alu_in2/alu_op; latch the grant id; go to EXEC.
REQ-007 Only the granted requester's ready SHALL be 1; both readys SHALL be 0 outside IDLE.
REQ-008 Arbitration SHALL be round-robin on last_grant:
- single valid wins;
- both valid: requester != last_grant wins.
REQ-009 EXEC: capture alu_out into rsp_out; go to RESP (exactly one cycle).
REQ-010 RESP: assert rspN_valid for the granted id only, with rsp_out stable.
- While rspN_ready=0: hold RESP and rsp_out.
- On rspN_ready=1: update last_grant to the granted id and go to IDLE.
REQ-011 Timing: accept in cycle T, rspN_valid=1 from cycle T+2; minimum spacing between accepts is 3 cycles.
REQ-012 A new request SHALL NOT be accepted in the cycle the response handshake completes.
REQ-013 alu_in1, alu_in2 and alu_op SHALL hold their values outside IDLE-accept cycles.
REQ-014 reqN_valid deasserting while not granted SHALL be legal and have no effect.

Reset
REQ-015 On rst=1 at a clock edge:
- state=IDLE, last_grant=1 (requester 0 wins the first tie);
- alu_in1, alu_in2, alu_op, rsp_out = 0;
- rsp0_valid = rsp1_valid = 0; req readys = 0 during reset.
REQ-016 Reset in EXEC or RESP SHALL discard the in-flight operation; no response is issued.

Configuration
REQ-017 With ALU_ARB_STATS_EN defined: add outputs grant_cnt0 and grant_cnt1 (16 bits each), incremented on each accept by requester N, wrapping 0xFFFF->0, reset to 0.
REQ-018 Without ALU_ARB_STATS_EN: the ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-019 Package alu_arb_pkg SHALL hold the state enum (IDLE/EXEC/RESP) and the DW, OPW and OP_LSB default constants.
REQ-020 The two-way round-robin grant SHALL be the sub-module alu_arb_rr:
- inputs: valid pair and last_grant;
- outputs: grant id and any_valid.
REQ-021 The ALU32 and the decoder SHALL stay outside this block; alu_arbiter only sequences them.

Verification
REQ-022 Bench SHALL cover:
- Single request: req0 in1=5, in2=3, instr=0x04000000 (op=1), alu model returns 8 -> req0_ready at T, rsp0_valid at T+2, rsp_out=8.
- Tie after reset: both valid -> req0 granted first; next tie -> req1 granted; alternation continues.
- Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid and rsp_out held stable; no req accepted until the handshake, no accept in the handshake cycle.
- Reset mid-op: rst in EXEC -> next cycle IDLE, no rspN_valid, rsp_out=0, last_grant=1.
- Stats (ALU_ARB_STATS_EN defined): 3 req0 and 2 req1 accepts -> grant_cnt0=3, grant_cnt1=2; preload 0xFFFF plus one accept -> 0.
- Opcode extraction: instr=0xFC000000 -> alu_op=0x3F; low-bit-only instr 0x0000003F -> alu_op=0.
